mlp_mac_sched: RTL and testbench

MLP_MAC_SCHED -- requirements
Module: mlp_mac_sched

---
 rtl/mlp_mac_sched.sv | 126 ++++++++++++
 tb/tb_mlp_mac_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_mac_sched.sv
// Single-neuron MLP multiply-accumulate scheduler: one shared 16x15 multiplier, IDLE/RUN/DRAIN/DONE.
// Optional MLP_MAC_SAT_EN selects a saturating output stage instead of 16-bit wrap-around.
module mlp_mac_sched #(
  parameter int N_TERMS = 8,
  parameter int ADDR_W  = 3,
  parameter int ACC_W   = 36,
  parameter int SHIFT   = 10
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  output logic                     ap_done,
  output logic                     ap_idle,
  output logic                     ap_ready,
  output logic [ADDR_W-1:0]        x_addr,
  input  logic signed [15:0]       x_q,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic [14:0]              w_q,
  input  logic signed [15:0]       bias,
  output logic signed [15:0]       y
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0]  Y_MAX     = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0]  Y_MIN     = ACC_W'(-32'sd32768);

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]         x_addr_q, x_addr_d;
  logic signed [15:0]        y_q, y_d;
  logic                      vld_q;
  logic signed [31:0]        prod_full;
  logic signed [30:0]        prod;
  logic signed [ACC_W-1:0]   acc_sh;

  // Weight is zero-extended so the product is always a 31-bit signed value.
  assign prod_full = x_q * $signed({1'b0, w_q});
  assign prod      = prod_full[30:0];
  assign acc_sh    = acc_d >>> SHIFT;

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      x_addr_q <= '0;
      y_q      <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      x_addr_q <= x_addr_d;
      y_q      <= y_d;
      vld_q    <= (state_q == S_RUN);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = ap_start ? S_RUN : S_IDLE;
      S_RUN:   state_d = (x_addr_q == LAST_ADDR) ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operands return one cycle after their address, tracked by vld_q.
  always_comb begin
    acc_d    = acc_q;
    x_addr_d = x_addr_q;
    y_d      = y_q;
    if (state_q == S_IDLE && ap_start) begin
      acc_d    = {{(ACC_W-16){bias[15]}}, bias};
      x_addr_d = '0;
    end else if (vld_q) begin
      acc_d = acc_q + {{(ACC_W-31){prod[30]}}, prod};
    end else begin
      acc_d = acc_q;
    end
    if (state_q == S_RUN && x_addr_q != LAST_ADDR) begin
      x_addr_d = x_addr_q + ADDR_W'(1);
    end else begin
      x_addr_d = x_addr_d;
    end
    if (state_q == S_DRAIN) begin
`ifdef MLP_MAC_SAT_EN
      if (acc_sh > Y_MAX) begin
        y_d = 16'sh7fff;
      end else if (acc_sh < Y_MIN) begin
        y_d = -16'sh8000;
      end else begin
        y_d = acc_sh[15:0];
      end
`else
      y_d = acc_sh[15:0];
`endif
    end else begin
      y_d = y_q;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    case (state_q)
      S_IDLE:  ap_idle = 1'b1;
      S_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
      end
      default: ap_idle = 1'b0;
    endcase
  end

  assign x_addr = x_addr_q;
  assign w_addr = x_addr_q;
  assign y      = y_q;

endmodule

// File: tb/tb_mlp_mac_sched.sv
// Scoreboard bench for mlp_mac_sched: drivers push expected {y, done cycle}, a negedge monitor checks.
module tb_mlp_mac_sched;
  localparam int N = 8;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               ap_start = 1'b0;
  logic               ap_done, ap_idle, ap_ready;
  logic [2:0]         x_addr, w_addr;
  logic signed [15:0] x_q = '0;
  logic [14:0]        w_q = '0;
  logic signed [15:0] bias = '0;
  logic signed [15:0] y;

  logic signed [15:0] x_mem [N];
  logic [14:0]        w_mem [N];

  typedef struct { logic signed [15:0] y; int cyc; } exp_t;
  exp_t sb_q [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mlp_mac_sched #(.N_TERMS(N), .ADDR_W(3), .ACC_W(36), .SHIFT(10)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .x_addr(x_addr), .x_q(x_q),
    .w_addr(w_addr), .w_q(w_q), .bias(bias), .y(y)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Synchronous-read operand memories.
  always @(posedge ap_clk) begin
    x_q <= x_mem[x_addr];
    w_q <= w_mem[w_addr];
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/ready pulse must match the head of the scoreboard.
  always @(negedge ap_clk) begin
    if (ap_rst_n && (ap_done || ap_ready)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(ap_done), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("y", 64'(y), 64'(e.y));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("ready_eq_done", 64'(ap_ready), 64'(ap_done));
      end
    end
  end

  task automatic fill(input logic signed [15:0] xv, input logic [14:0] wv);
    for (int i = 0; i < N; i++) begin
      x_mem[i] = xv;
      w_mem[i] = wv;
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200 && !ap_idle; k++) begin
      @(posedge ap_clk); #1;
    end
    if (!ap_idle) check("idle_timeout", 64'(ap_idle), 64'(1));
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 200 && sb_q.size() != 0; k++) begin
      @(posedge ap_clk); #1;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
    end
    repeat (N + 4) begin
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic start_run(input logic signed [15:0] b, input logic signed [15:0] ey);
    exp_t e;
    wait_idle();
    bias = b;
    ap_start = 1'b1;
    e.y = ey;
    e.cyc = cyc + N + 2;
    sb_q.push_back(e);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  initial begin
    exp_t e;
    int c;
    fill(16'sd0, 15'd0);
    #2;
    check("rst_idle", 64'(ap_idle), 64'(1));
    check("rst_done", 64'(ap_done), 64'(0));
    check("rst_ready", 64'(ap_ready), 64'(0));
    check("rst_y", 64'(y), 64'(0));
    check("rst_addr", 64'(x_addr), 64'(0));
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // 8 * 1024 * 1 >> 10 = 8
    fill(16'sd1024, 15'd1);
    start_run(16'sd0, 16'sd8);
    wait_drain();

    // 8 * -32768 * 32767 >> 10 = -8388352: saturates, or wraps to 0x0100
    fill(-16'sd32768, 15'd32767);
`ifdef MLP_MAC_SAT_EN
    start_run(16'sd0, -16'sd32768);
`else
    start_run(16'sd0, 16'sd256);
`endif
    wait_drain();

    // 8 * 32767^2 >> 10 = 0x7FFE00: saturates, or wraps to 0xFE00
    fill(16'sd32767, 15'd32767);
`ifdef MLP_MAC_SAT_EN
    start_run(16'sd0, 16'sd32767);
`else
    start_run(16'sd0, -16'sd512);
`endif
    wait_drain();

    // Mixed signs: 1e5 * (1-4+9-16+25-36+49-64) + 5000 = -3595000 >>> 10 = -3511
    for (int i = 0; i < N; i++) begin
      x_mem[i] = 16'((i % 2 == 0) ? (i + 1) * 1000 : -(i + 1) * 1000);
      w_mem[i] = 15'((i + 1) * 100);
    end
    start_run(16'sd5000, -16'sd3511);
    wait_drain();

    // Single term with mid-run start pulse and bias change: (-100 + 2048*512) >>> 10 = 1023
    fill(16'sd0, 15'd0);
    x_mem[3] = 16'sd2048;
    w_mem[3] = 15'd512;
    start_run(-16'sd100, 16'sd1023);
    bias = 16'sd30000;
    repeat (3) begin
      @(posedge ap_clk); #1;
    end
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_drain();

    // Same term, zero bias: 1048576 >>> 10 = 1024
    start_run(16'sd0, 16'sd1024);
    wait_drain();

    // ap_start held 40 cycles: runs start every N+3 cycles
    fill(16'sd1024, 15'd1);
    wait_idle();
    bias = 16'sd0;
    c = cyc;
    for (int r = 0; r < 4; r++) begin
      e.y = 16'sd8;
      e.cyc = c + r * (N + 3) + N + 2;
      sb_q.push_back(e);
    end
    ap_start = 1'b1;
    for (int k = 1; k < 40; k++) begin
      @(posedge ap_clk); #1;
      if (k == N + 3 || k == 2 * (N + 3)) check("held_idle", 64'(ap_idle), 64'(1));
      if (k == N + 4) check("held_busy", 64'(ap_idle), 64'(0));
    end
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_drain();

    // Reset in the middle of a run: abort, no done, fresh restart
    wait_idle();
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (4) begin
      @(posedge ap_clk); #1;
    end
    check("busy_before_rst", 64'(ap_idle), 64'(0));
    ap_rst_n = 1'b0;
    #1;
    check("midrst_idle", 64'(ap_idle), 64'(1));
    check("midrst_done", 64'(ap_done), 64'(0));
    check("midrst_y", 64'(y), 64'(0));
    check("midrst_addr", 64'(x_addr), 64'(0));
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (N + 4) begin
      @(posedge ap_clk); #1;
    end
    start_run(16'sd0, 16'sd8);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
